// File: rtl/rotate_led_monitor.sv
// Purpose: tracks a rotating one-hot LED pattern (position, direction, step period, stall, errors).
// Latency: all outputs are registered one cycle after the change edge; no backpressure (observe-only).
// Optional error counter enabled by defining LEDMON_ERRCNT_EN; otherwise err_cnt is tied to zero.
module rotate_led_monitor #(
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic        clk_FPGA,
    input  logic        reset,
    input  logic [4:0]  din,
    output logic [2:0]  pos,
    output logic        dir,
    output logic        step,
    output logic [15:0] period,
    output logic        stalled,
    output logic        err,
    output logic [7:0]  err_cnt
);

    logic [4:0]  din_r_q, din_r_d;
    logic [2:0]  pos_q, pos_d;
    logic        dir_q, dir_d;
    logic        step_q, step_d;
    logic [15:0] period_q, period_d;
    logic [15:0] cnt_q, cnt_d;
    logic        stalled_q, stalled_d;
    logic        err_q, err_d;

    logic        change;
    logic        new_hot, old_hot;
    logic [2:0]  new_idx, old_idx, old_prev, old_next;
    logic [15:0] cnt_inc;

    function automatic logic is_onehot(input logic [4:0] v);
        return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
    endfunction

    function automatic logic [2:0] hot_index(input logic [4:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    always_comb begin
        change   = (din != din_r_q);
        new_hot  = is_onehot(din);
        old_hot  = is_onehot(din_r_q);
        new_idx  = hot_index(din);
        old_idx  = hot_index(din_r_q);
        old_prev = (old_idx == 3'd0) ? 3'd4 : old_idx - 3'd1;
        old_next = (old_idx == 3'd4) ? 3'd0 : old_idx + 3'd1;
        cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

        din_r_d   = din;
        pos_d     = pos_q;
        dir_d     = dir_q;
        step_d    = change;
        period_d  = period_q;
        cnt_d     = cnt_inc;
        stalled_d = stalled_q;
        err_d     = 1'b0;

        if (change) begin
            cnt_d     = 16'd0;
            period_d  = cnt_inc;
            stalled_d = 1'b0;
            if (!new_hot) begin
                err_d = 1'b1;
            end else begin
                pos_d = new_idx;
                // Direction is only judged when the previous pattern was itself legal.
                if (old_hot) begin
                    if (new_idx == old_prev)      dir_d = 1'b1;
                    else if (new_idx == old_next) dir_d = 1'b0;
                    else                          err_d = 1'b1;
                end
            end
        end else if (cnt_inc == TIMEOUT) begin
            stalled_d = 1'b1;
        end
    end

    always_ff @(posedge clk_FPGA) begin
        if (!reset) begin
            din_r_q   <= 5'b00001;
            pos_q     <= 3'd0;
            dir_q     <= 1'b1;
            step_q    <= 1'b0;
            period_q  <= 16'd0;
            cnt_q     <= 16'd0;
            stalled_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            din_r_q   <= din_r_d;
            pos_q     <= pos_d;
            dir_q     <= dir_d;
            step_q    <= step_d;
            period_q  <= period_d;
            cnt_q     <= cnt_d;
            stalled_q <= stalled_d;
            err_q     <= err_d;
        end
    end

`ifdef LEDMON_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk_FPGA) begin
        if (!reset) begin
            err_cnt_q <= 8'd0;
        end else if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

    assign pos     = pos_q;
    assign dir     = dir_q;
    assign step    = step_q;
    assign period  = period_q;
    assign stalled = stalled_q;
    assign err     = err_q;

endmodule

// File: tb/tb_rotate_led_monitor.sv
// Directed bench for rotate_led_monitor with TIMEOUT=20; expected values are hand-computed.
module tb_rotate_led_monitor;

    logic        clk_FPGA;
    logic        reset;
    logic [4:0]  din;
    logic [2:0]  pos;
    logic        dir;
    logic        step;
    logic [15:0] period;
    logic        stalled;
    logic        err;
    logic [7:0]  err_cnt;

    int n_checks;
    int n_fail;

    rotate_led_monitor #(.TIMEOUT(16'd20)) dut (
        .clk_FPGA (clk_FPGA),
        .reset    (reset),
        .din      (din),
        .pos      (pos),
        .dir      (dir),
        .step     (step),
        .period   (period),
        .stalled  (stalled),
        .err      (err),
        .err_cnt  (err_cnt)
    );

    initial clk_FPGA = 1'b0;
    always #5 clk_FPGA = ~clk_FPGA;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_FPGA);
            #1;
        end
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_pos"}, 32'(pos), 32'd0);
        check_eq({tag, "_dir"}, 32'(dir), 32'd1);
        check_eq({tag, "_step"}, 32'(step), 32'd0);
        check_eq({tag, "_period"}, 32'(period), 32'd0);
        check_eq({tag, "_stalled"}, 32'(stalled), 32'd0);
        check_eq({tag, "_err"}, 32'(err), 32'd0);
        check_eq({tag, "_errcnt"}, 32'(err_cnt), 32'd0);
    endtask

    logic [7:0] exp_errcnt;

    initial begin
        n_checks = 0;
        n_fail   = 0;
`ifdef LEDMON_ERRCNT_EN
        exp_errcnt = 8'd2;
`else
        exp_errcnt = 8'd0;
`endif
        reset = 1'b0;
        din   = 5'b00001;
        tick(2);
        check_reset_state("rst");

        reset = 1'b1;
        tick(1);
        check_eq("idle_step", 32'(step), 32'd0);

        // 0 -> 4 wrap (right), then 4 -> 3 ten cycles later
        din = 5'b10000; tick(1);
        check_eq("r1_step", 32'(step), 32'd1);
        check_eq("r1_pos", 32'(pos), 32'd4);
        check_eq("r1_dir", 32'(dir), 32'd1);
        check_eq("r1_err", 32'(err), 32'd0);
        tick(1);
        check_eq("r1_step_pulse", 32'(step), 32'd0);
        tick(8);
        din = 5'b01000; tick(1);
        check_eq("r2_step", 32'(step), 32'd1);
        check_eq("r2_pos", 32'(pos), 32'd3);
        check_eq("r2_dir", 32'(dir), 32'd1);
        check_eq("r2_period", 32'(period), 32'd10);
        check_eq("r2_err", 32'(err), 32'd0);

        // left: 3 -> 4 -> 0 (wrap) -> 1 every 4 cycles
        din = 5'b10000; tick(1);
        check_eq("l1_dir", 32'(dir), 32'd0);
        tick(3);
        din = 5'b00001; tick(1);
        check_eq("l2_pos", 32'(pos), 32'd0);
        check_eq("l2_dir", 32'(dir), 32'd0);
        check_eq("l2_period", 32'(period), 32'd4);
        tick(3);
        din = 5'b00010; tick(1);
        check_eq("l3_pos", 32'(pos), 32'd1);
        check_eq("l3_dir", 32'(dir), 32'd0);
        check_eq("l3_period", 32'(period), 32'd4);
        check_eq("l3_err", 32'(err), 32'd0);

        // back to 0 (right), then illegal jump and a non-one-hot pattern
        din = 5'b00001; tick(1);
        check_eq("e0_dir", 32'(dir), 32'd1);
        din = 5'b00100; tick(1);
        check_eq("e1_err", 32'(err), 32'd1);
        check_eq("e1_step", 32'(step), 32'd1);
        check_eq("e1_pos", 32'(pos), 32'd2);
        check_eq("e1_dir", 32'(dir), 32'd1);
        din = 5'b00110; tick(1);
        check_eq("e2_err", 32'(err), 32'd1);
        check_eq("e2_step", 32'(step), 32'd1);
        check_eq("e2_pos", 32'(pos), 32'd2);
        check_eq("e2_dir", 32'(dir), 32'd1);
        check_eq("e2_errcnt", 32'(err_cnt), 32'(exp_errcnt));
        tick(1);
        check_eq("e3_err_pulse", 32'(err), 32'd0);

        // legal after illegal: pos updates, dir held, no err
        din = 5'b01000; tick(1);
        check_eq("rec_pos", 32'(pos), 32'd3);
        check_eq("rec_step", 32'(step), 32'd1);
        check_eq("rec_err", 32'(err), 32'd0);
        check_eq("rec_dir", 32'(dir), 32'd1);

        // stall after 20 quiet cycles, then change
        tick(19);
        check_eq("st_19", 32'(stalled), 32'd0);
        tick(1);
        check_eq("st_20", 32'(stalled), 32'd1);
        din = 5'b10000; tick(1);
        check_eq("st_clr", 32'(stalled), 32'd0);
        check_eq("st_period", 32'(period), 32'd21);
        check_eq("st_dir", 32'(dir), 32'd0);

        // change coincident with cnt reaching TIMEOUT
        tick(19);
        din = 5'b00001; tick(1);
        check_eq("co_stalled", 32'(stalled), 32'd0);
        check_eq("co_period", 32'(period), 32'd20);
        tick(1);
        check_eq("co_stalled2", 32'(stalled), 32'd0);

        // long hold saturates period
        din = 5'b10000; tick(70000);
        check_eq("sat_stalled", 32'(stalled), 32'd1);
        din = 5'b00001; tick(1);
        check_eq("sat_period", 32'(period), 32'h0000FFFF);
        check_eq("sat_pos", 32'(pos), 32'd0);

        // reset while a step is in flight
        din = 5'b00010; tick(1);
        check_eq("mid_step", 32'(step), 32'd1);
        reset = 1'b0;
        din   = 5'b00100;
        tick(1);
        check_reset_state("mid_rst");

        // first change after reset compares against 00001
        din = 5'b00010;
        reset = 1'b1;
        tick(1);
        check_eq("post_pos", 32'(pos), 32'd1);
        check_eq("post_dir", 32'(dir), 32'd0);
        check_eq("post_step", 32'(step), 32'd1);
        check_eq("post_err", 32'(err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
